// File: rtl/thresh_ramp_pkg.sv
// Shared types and constants for the threshold ramp controller and its dry-path delay.
// Holds the FSM state encoding, the threshold ceiling and the default parameter values.
package thresh_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        TO_BYP,
        BYP
    } state_t;

    localparam logic [3:0]  THRESH_MAX       = 4'hF;
    localparam int unsigned DEF_STEP_SAMPLES = 64;
    localparam logic [3:0]  DEF_RESET_THRESH = 4'd8;
    localparam int unsigned DEF_COMP_LAT     = 4;
    localparam int unsigned AUDIO_W          = 16;

    // One LSB toward goal; goal is always within 0..15, so this never wraps.
    function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] goal);
        if (goal > cur) begin
            return cur + 4'd1;
        end else if (goal < cur) begin
            return cur - 4'd1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/flex_buffer.sv
// Single pipeline register stage of configurable width; one link of the dry delay line.
module flex_buffer #(
    parameter int unsigned NUM_BITS = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] data_in,
    output logic [NUM_BITS-1:0] data_out
);

    logic [NUM_BITS-1:0] data_q;

    // NOTE: the delay line is reset so audio_out is silence, not stale samples, after reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_in;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/thresh_ramp_ctrl_dry_delay.sv
// Dry-path delay matching the compressor latency: a chain of COMP_LAT register stages.
module dry_delay
    import thresh_ramp_pkg::*;
#(
    parameter int unsigned COMP_LAT = DEF_COMP_LAT,
    parameter int unsigned NUM_BITS = AUDIO_W
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] dry_in,
    output logic [NUM_BITS-1:0] dry_out
);

    logic [NUM_BITS-1:0] stage [COMP_LAT+1];

    assign stage[0] = dry_in;

    for (genvar i = 0; i < COMP_LAT; i++) begin : g_stage
        flex_buffer #(
            .NUM_BITS (NUM_BITS)
        ) u_buf (
            .clk      (clk),
            .n_rst    (n_rst),
            .data_in  (stage[i]),
            .data_out (stage[i+1])
        );
    end

    assign dry_out = stage[COMP_LAT];

endmodule

// File: rtl/thresh_ramp_ctrl.sv
// Ramps the compressor threshold one LSB per STEP_SAMPLES sample ticks toward a host target,
// sequences click-free bypass entry/exit, and registers the final wet/dry audio output.
module thresh_ramp_ctrl
    import thresh_ramp_pkg::*;
#(
    parameter int unsigned STEP_SAMPLES = DEF_STEP_SAMPLES,
    parameter logic [3:0]  RESET_THRESH = DEF_RESET_THRESH,
    parameter int unsigned COMP_LAT     = DEF_COMP_LAT
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        sample_tick,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [3:0]  cfg_thresh,
    input  logic        cfg_bypass,
    output logic [3:0]  thresh_out,
    output logic        bypass,
    output logic        ramp_active,
    output logic        ramp_done,
    input  logic [15:0] dry_in,
    input  logic [15:0] wet_in,
    output logic [15:0] audio_out
);

    localparam int unsigned     CNT_W    = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_SAMPLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       thresh_q, thresh_d;
    logic [3:0]       target_q, target_d;
    logic             bypass_q, bypass_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [15:0]      audio_q, audio_d;
    logic [15:0]      dry_dly;
    logic             accept;
    logic             ramping;
    logic             step_evt;
    logic [3:0]       next_thresh;

    assign cfg_ready   = (state_q == IDLE) || (state_q == BYP);
    assign ramping     = (state_q == RAMP) || (state_q == TO_BYP);
    assign accept      = cfg_valid && cfg_ready;
    assign step_evt    = ramping && sample_tick && (step_cnt_q == CNT_LAST);
    assign next_thresh = step_toward(thresh_q, (state_q == TO_BYP) ? THRESH_MAX : target_q);

    // Counter is zero outside the ramp states, which also covers the clear on accept.
    always_comb begin : step_counter
        step_cnt_d = '0;
        if (ramping && !step_evt) begin
            step_cnt_d = sample_tick ? step_cnt_q + 1'b1 : step_cnt_q;
        end
    end

    always_comb begin : fsm_next
        // NOTE: every _d gets a default before the case, so no path can infer a latch.
        state_d  = state_q;
        thresh_d = thresh_q;
        target_d = target_q;
        bypass_d = bypass_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d = cfg_thresh;
                    if (cfg_bypass) begin
                        if (thresh_q == THRESH_MAX) begin
                            state_d  = BYP;
                            bypass_d = 1'b1;
                            done_d   = 1'b1;
                        end else begin
                            state_d = TO_BYP;
                        end
                    end else if (cfg_thresh == thresh_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (step_evt) begin
                    thresh_d = next_thresh;
                    if (next_thresh == target_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            TO_BYP: begin
                if (step_evt) begin
                    thresh_d = next_thresh;
                    if (next_thresh == THRESH_MAX) begin
                        state_d  = BYP;
                        bypass_d = 1'b1;
                        done_d   = 1'b1;
                    end
                end
            end
            BYP: begin
                if (accept) begin
                    target_d = cfg_thresh;
                    if (cfg_bypass) begin
                        done_d = 1'b1;
                    end else begin
                        // Leave the dry path first; the ramp down runs on the wet path.
                        bypass_d = 1'b0;
                        if (cfg_thresh == thresh_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RAMP;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign audio_d = bypass_q ? dry_dly : wet_in;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            thresh_q   <= RESET_THRESH;
            target_q   <= RESET_THRESH;
            bypass_q   <= 1'b0;
            done_q     <= 1'b0;
            step_cnt_q <= '0;
            audio_q    <= '0;
        end else begin
            state_q    <= state_d;
            thresh_q   <= thresh_d;
            target_q   <= target_d;
            bypass_q   <= bypass_d;
            done_q     <= done_d;
            step_cnt_q <= step_cnt_d;
            audio_q    <= audio_d;
        end
    end

    dry_delay #(
        .COMP_LAT (COMP_LAT),
        .NUM_BITS (16)
    ) u_dry_delay (
        .clk     (clk),
        .n_rst   (n_rst),
        .dry_in  (dry_in),
        .dry_out (dry_dly)
    );

    assign thresh_out  = thresh_q;
    assign bypass      = bypass_q;
    assign ramp_active = ramping;
    assign ramp_done   = done_q;
    assign audio_out   = audio_q;

endmodule

// File: tb/tb_thresh_ramp_ctrl.sv
// Directed bench for thresh_ramp_ctrl with STEP_SAMPLES=4, COMP_LAT=4; expectations hand-computed.
module tb_thresh_ramp_ctrl;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        sample_tick = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_bypass = 1'b0;
    logic [3:0]  cfg_thresh = 4'd0;
    logic        cfg_ready;
    logic        bypass;
    logic        ramp_active;
    logic        ramp_done;
    logic [3:0]  thresh_out;
    logic [15:0] dry_in = 16'h0;
    logic [15:0] wet_in = 16'h0;
    logic [15:0] audio_out;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    thresh_ramp_ctrl #(
        .STEP_SAMPLES (4),
        .RESET_THRESH (4'd8),
        .COMP_LAT     (4)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .sample_tick (sample_tick),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_thresh  (cfg_thresh),
        .cfg_bypass  (cfg_bypass),
        .thresh_out  (thresh_out),
        .bypass      (bypass),
        .ramp_active (ramp_active),
        .ramp_done   (ramp_done),
        .dry_in      (dry_in),
        .wet_in      (wet_in),
        .audio_out   (audio_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs at a falling edge, cross one rising edge, return at the next falling edge.
    task automatic cyc(input logic tick);
        sample_tick = tick;
        @(posedge clk);
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_thresh"}, int'(thresh_out), 8);
        check({pfx, "_bypass"}, int'(bypass), 0);
        check({pfx, "_ready"},  int'(cfg_ready), 1);
        check({pfx, "_audio"},  int'(audio_out), 0);
        check({pfx, "_done"},   int'(ramp_done), 0);
        check({pfx, "_active"}, int'(ramp_active), 0);
    endtask

    initial begin
        // Power-on reset.
        @(posedge clk);
        @(negedge clk);
        check_reset_values("por");
        n_rst = 1'b1;
        cyc(1'b0);

        // Request equal to the current threshold: no ramp, done on the next cycle.
        cfg_valid = 1'b1; cfg_thresh = 4'd8; cfg_bypass = 1'b0;
        cyc(1'b0);
        cfg_valid = 1'b0;
        check("eq_done",   int'(ramp_done), 1);
        check("eq_active", int'(ramp_active), 0);
        check("eq_thresh", int'(thresh_out), 8);
        cyc(1'b0);
        check("eq_done_clr", int'(ramp_done), 0);

        // 8 -> 11: one LSB per 4 counted ticks, one done pulse with the final step.
        cfg_valid = 1'b1; cfg_thresh = 4'd11;
        cyc(1'b0);
        cfg_valid = 1'b0;
        check("up_active", int'(ramp_active), 1);
        check("up_ready",  int'(cfg_ready), 0);
        done_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc(1'b1);
            done_cnt += int'(ramp_done);
            if (k % 4 == 0) check($sformatf("up_thresh_t%0d", k), int'(thresh_out), 8 + k / 4);
            if (k == 12) check("up_done_final", int'(ramp_done), 1);
            cyc(1'b0);
            done_cnt += int'(ramp_done);
        end
        check("up_done_count", done_cnt, 1);
        check("up_ready_back", int'(cfg_ready), 1);
        check("up_active_off", int'(ramp_active), 0);

        // Asynchronous reset mid-ramp with live audio.
        wet_in = 16'hC3C3;
        cfg_valid = 1'b1; cfg_thresh = 4'd3;
        cyc(1'b0);
        cfg_valid = 1'b0;
        for (int k = 0; k < 5; k++) cyc(1'b1);
        check("mid_thresh", int'(thresh_out), 10);
        check("mid_audio",  int'(audio_out), 'hC3C3);
        #2 n_rst = 1'b0;
        #1 check_reset_values("arst");
        @(negedge clk);
        n_rst = 1'b1;
        wet_in = 16'h0;
        for (int k = 0; k < 8; k++) cyc(1'b1);
        check("arst_target_lost", int'(thresh_out), 8);
        check("arst_idle",        int'(ramp_active), 0);

        // 8 -> 6 with a tick in the accept cycle; a held request waits for IDLE.
        cfg_valid = 1'b1; cfg_thresh = 4'd6;
        cyc(1'b1);
        check("dn_active", int'(ramp_active), 1);
        cfg_thresh = 4'd13;
        for (int k = 0; k < 3; k++) cyc(1'b1);
        check("dn_accept_tick_ignored", int'(thresh_out), 8);
        cyc(1'b1);
        check("dn_thresh_7", int'(thresh_out), 7);
        for (int k = 0; k < 3; k++) cyc(1'b1);
        check("dn_held_not_accepted", int'(cfg_ready), 0);
        cyc(1'b1);
        check("dn_thresh_6", int'(thresh_out), 6);
        check("dn_done",     int'(ramp_done), 1);
        check("dn_ready",    int'(cfg_ready), 1);
        cyc(1'b0);
        check("held_accepted_active", int'(ramp_active), 1);
        check("held_accepted_ready",  int'(cfg_ready), 0);
        check("held_done_clr",        int'(ramp_done), 0);
        cfg_valid = 1'b0;
        for (int k = 0; k < 28; k++) cyc(1'b1);
        check("held_thresh_13", int'(thresh_out), 13);
        check("held_idle",      int'(ramp_active), 0);

        // Enter bypass from 13: 14, 15, then bypass with done.
        cfg_valid = 1'b1; cfg_bypass = 1'b1; cfg_thresh = 4'd5;
        cyc(1'b0);
        cfg_valid = 1'b0;
        check("tobyp_active", int'(ramp_active), 1);
        check("tobyp_ready",  int'(cfg_ready), 0);
        for (int k = 0; k < 4; k++) cyc(1'b1);
        check("tobyp_thresh_14", int'(thresh_out), 14);
        check("tobyp_bypass_0",  int'(bypass), 0);
        for (int k = 0; k < 4; k++) cyc(1'b1);
        check("byp_thresh_15", int'(thresh_out), 15);
        check("byp_bypass_1",  int'(bypass), 1);
        check("byp_done",      int'(ramp_done), 1);
        check("byp_active",    int'(ramp_active), 0);
        check("byp_ready",     int'(cfg_ready), 1);

        // Dry latency through the delay line: 5 edges to audio_out.
        wet_in = 16'hBEEF;
        dry_in = 16'h1234;
        cyc(1'b0);
        dry_in = 16'h0;
        for (int k = 0; k < 3; k++) cyc(1'b0);
        check("dry_edge4", int'(audio_out), 0);
        cyc(1'b0);
        check("dry_edge5", int'(audio_out), 'h1234);
        cyc(1'b0);
        check("dry_edge6", int'(audio_out), 0);

        // Bypass request while already bypassed: done pulse, stay put.
        cfg_valid = 1'b1; cfg_bypass = 1'b1; cfg_thresh = 4'd3;
        cyc(1'b0);
        cfg_valid = 1'b0;
        check("byp_again_done",   int'(ramp_done), 1);
        check("byp_again_bypass", int'(bypass), 1);
        check("byp_again_thresh", int'(thresh_out), 15);

        // Leave bypass to 12: bypass clears first, then 15 -> 12 on the wet path.
        cfg_valid = 1'b1; cfg_bypass = 1'b0; cfg_thresh = 4'd12;
        wet_in = 16'hA5A5;
        cyc(1'b0);
        cfg_valid = 1'b0;
        check("exit_bypass_0",  int'(bypass), 0);
        check("exit_active",    int'(ramp_active), 1);
        check("exit_last_dry",  int'(audio_out), 0);
        wet_in = 16'h5A5A;
        cyc(1'b1);
        check("exit_first_wet", int'(audio_out), 'h5A5A);
        wet_in = 16'h0F0F;
        cyc(1'b1);
        check("exit_wet_lat", int'(audio_out), 'h0F0F);
        for (int k = 3; k <= 4; k++) cyc(1'b1);
        check("exit_thresh_14", int'(thresh_out), 14);
        for (int k = 5; k <= 8; k++) cyc(1'b1);
        check("exit_thresh_13", int'(thresh_out), 13);
        for (int k = 9; k <= 11; k++) cyc(1'b1);
        check("exit_thresh_hold", int'(thresh_out), 13);
        cyc(1'b1);
        check("exit_thresh_12", int'(thresh_out), 12);
        check("exit_done",      int'(ramp_done), 1);
        check("exit_ready",     int'(cfg_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
